mem_port_arbiter: RTL and testbench

//  Shares one single-ported 16-bit instruction/data RAM between the IF-stage fetch port and the MEM-stage load/store port.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/arb_starve_counter.sv | 33 +++
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---- mem_arb_pkg: arbiter state encoding and default bus widths ---- rev 1.0
package mem_arb_pkg;
   localparam int ARB_AW = 16;
   localparam int ARB_DW = 16;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_FETCH = 2'd1;
   localparam logic [1:0] ARB_DATA  = 2'd2;
endpackage
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// ---- arb_starve_counter: saturating count of data grants that bypassed a waiting fetch ---- rev 1.0
module arb_starve_counter #(
   parameter int MAX = 4,
   parameter int CW  = $clog2(MAX + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_inc,
   input  logic          i_clr,
   output logic [CW-1:0] o_cnt,
   output logic          o_sat
);
   logic [CW-1:0] r_cnt;
   logic          w_sat;

   assign w_sat = (r_cnt == CW'(MAX));

   // Clear wins so a fetch grant always restarts the starvation window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_sat) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_sat = w_sat;
endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---- mem_port_arbiter: fetch / load-store arbiter for one single-ported RAM, data priority ---- rev 1.0
// ---- Optional one-entry fetch buffer enabled by ARB_FETCH_BUF_EN ----
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = ARB_AW,
   parameter int DW         = ARB_DW,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_instr,
   output logic          if_done,
   output logic          if_stall,
   input  logic          mem_rd,
   input  logic          mem_wr,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] mem_rdata,
   output logic          mem_done,
   output logic          mem_stall,
   output logic          ram_req,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   input  logic          ram_ack
);
   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic          r_ram_req;
   logic          r_ram_we;
   logic [AW-1:0] r_ram_addr;
   logic [DW-1:0] r_ram_wdata;
   logic [DW-1:0] r_if_instr;
   logic [DW-1:0] r_mem_rdata;
   logic          r_if_done;
   logic          r_mem_done;

   logic          w_data_pend;
   logic          w_forced;
   logic          w_grant_data;
   logic          w_grant_fetch;
   logic          w_buf_serve;
   logic          w_fetch_cmpl;
   logic          w_data_cmpl;
   logic          w_buf_hit;
   logic [DW-1:0] w_buf_instr;
   logic [CW-1:0] w_starve_cnt;
   logic          w_starve_sat;

   arb_starve_counter #(
      .MAX (STARVE_MAX),
      .CW  (CW)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_grant_data & if_req),
      .i_clr (~if_req | w_grant_fetch | w_buf_serve),
      .o_cnt (w_starve_cnt),
      .o_sat (w_starve_sat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_grant_data) begin
               w_state_nxt = ARB_DATA;
            end else if (w_grant_fetch) begin
               w_state_nxt = ARB_FETCH;
            end
         end
         ARB_FETCH, ARB_DATA: begin
            if (ram_ack) begin
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // Grant/complete decode; ram_ack only matters while a transaction is open.
   always_comb begin
      w_data_pend   = mem_rd | mem_wr;
      w_forced      = if_req & w_starve_sat;
      w_grant_data  = 1'b0;
      w_grant_fetch = 1'b0;
      w_buf_serve   = 1'b0;
      w_fetch_cmpl  = 1'b0;
      w_data_cmpl   = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_data_pend && !w_forced) begin
               w_grant_data = 1'b1;
            end else if (if_req) begin
               w_buf_serve   = w_buf_hit;
               w_grant_fetch = ~w_buf_hit;
            end
         end
         ARB_FETCH: w_fetch_cmpl = ram_ack;
         ARB_DATA:  w_data_cmpl  = ram_ack;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ram_req   <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_if_instr  <= '0;
         r_mem_rdata <= '0;
         r_if_done   <= 1'b0;
         r_mem_done  <= 1'b0;
      end else begin
         r_if_done  <= w_fetch_cmpl | w_buf_serve;
         r_mem_done <= w_data_cmpl;
         // Simultaneous rd+wr falls through as a store via mem_wr.
         if (w_grant_data) begin
            r_ram_req   <= 1'b1;
            r_ram_we    <= mem_wr;
            r_ram_addr  <= mem_addr;
            r_ram_wdata <= mem_wdata;
         end else if (w_grant_fetch) begin
            r_ram_req  <= 1'b1;
            r_ram_we   <= 1'b0;
            r_ram_addr <= if_addr;
         end else if (w_fetch_cmpl || w_data_cmpl) begin
            r_ram_req <= 1'b0;
         end
         if (w_fetch_cmpl) begin
            r_if_instr <= ram_rdata;
         end else if (w_buf_serve) begin
            r_if_instr <= w_buf_instr;
         end
         if (w_data_cmpl && !r_ram_we) begin
            r_mem_rdata <= ram_rdata;
         end
      end
   end

`ifdef ARB_FETCH_BUF_EN
   logic          r_buf_valid;
   logic [AW-1:0] r_buf_tag;
   logic [DW-1:0] r_buf_instr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf_valid <= 1'b0;
         r_buf_tag   <= '0;
         r_buf_instr <= '0;
      end else if (w_fetch_cmpl) begin
         r_buf_valid <= 1'b1;
         r_buf_tag   <= r_ram_addr;
         r_buf_instr <= ram_rdata;
      end else if (w_grant_data && mem_wr && (mem_addr == r_buf_tag)) begin
         r_buf_valid <= 1'b0;
      end
   end

   assign w_buf_hit   = r_buf_valid && (r_buf_tag == if_addr);
   assign w_buf_instr = r_buf_instr;
`else
   assign w_buf_hit   = 1'b0;
   assign w_buf_instr = '0;
`endif

   assign ram_req   = r_ram_req;
   assign ram_we    = r_ram_we;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign if_instr  = r_if_instr;
   assign if_done   = r_if_done;
   assign mem_rdata = r_mem_rdata;
   assign mem_done  = r_mem_done;
   assign if_stall  = if_req & ~r_if_done;
   assign mem_stall = (mem_rd | mem_wr) & ~r_mem_done;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---- tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter ---- rev 1.0
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, mem_rd, mem_wr;
   logic [15:0] if_addr, mem_addr, mem_wdata;
   logic [15:0] if_instr, mem_rdata, ram_addr, ram_wdata;
   logic [15:0] ram_rdata = 16'h0;
   logic        if_done, if_stall, mem_done, mem_stall, ram_req, ram_we, ram_ack;
   logic        model_ack = 1'b0;
   logic        force_ack = 1'b0;

   logic [15:0] tb_mem [0:1023];
   int          ack_delay = 0;
   int          wait_cnt = 0;
   int          req_cycles = 0;
   int          ram_writes = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;
   assign ram_ack = model_ack | force_ack;

   mem_port_arbiter u_dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_instr  (if_instr),
      .if_done   (if_done),
      .if_stall  (if_stall),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_done  (mem_done),
      .mem_stall (mem_stall),
      .ram_req   (ram_req),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_ack   (ram_ack)
   );

   // RAM model: acks after ack_delay extra request cycles, driven on the falling edge.
   always @(negedge clk) begin
      if (ram_req && !reset) begin
         req_cycles = req_cycles + 1;
         ram_rdata  = tb_mem[ram_addr[9:0]];
         if (wait_cnt == ack_delay) begin
            model_ack = 1'b1;
            if (ram_we) begin
               tb_mem[ram_addr[9:0]] = ram_wdata;
               ram_writes = ram_writes + 1;
            end
         end else begin
            model_ack = 1'b0;
         end
         wait_cnt = wait_cnt + 1;
      end else begin
         model_ack = 1'b0;
         wait_cnt  = 0;
      end
   end

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input string tag, input logic [15:0] addr,
                           input logic [15:0] exp_instr, input logic exp_ram);
      if_req  = 1'b1;
      if_addr = addr;
      tick();
      check({tag, "_ram_req"}, ram_req, exp_ram);
      if (exp_ram) tick();
      check({tag, "_done"}, if_done, 1'b1);
      check({tag, "_instr"}, if_instr, exp_instr);
      if_req = 1'b0;
      tick();
   endtask

   initial begin
      int stores, stores_at, cnt_at, w0, base;
      logic fetch_seen;
      for (int i = 0; i < 1024; i++) tb_mem[i] = 16'h0;
      tb_mem[16'h0010] = 16'h3A41;
      tb_mem[16'h0020] = 16'h1234;
      tb_mem[16'h0030] = 16'hC0DE;
      tb_mem[16'h0200] = 16'h00FF;
      reset = 1'b1; if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      if_addr = 16'h0; mem_addr = 16'h0; mem_wdata = 16'h0;
      tick(); tick();
      check("rst_ctrl", {ram_req, ram_we, if_done, mem_done}, 4'b0000);
      check("rst_data", {ram_addr, ram_wdata, if_instr}, 48'h0);
      check("rst_rdata", mem_rdata, 16'h0);
      check("rst_starve", u_dut.w_starve_cnt, 3'd0);
      reset = 1'b0;
      tick();

      // Fetch only, ack in the request cycle.
      if_req = 1'b1; if_addr = 16'h0010;
      #1 check("t1_stall", if_stall, 1'b1);
      tick();
      check("t1_req", {ram_req, ram_we, ram_addr}, {1'b1, 1'b0, 16'h0010});
      check("t1_no_early_done", if_done, 1'b0);
      tick();
      check("t1_req_drop", ram_req, 1'b0);
      check("t1_done", if_done, 1'b1);
      check("t1_instr", if_instr, 16'h3A41);
      check("t1_stall_off", if_stall, 1'b0);
      if_req = 1'b0;
      tick();
      check("t1_pulse", if_done, 1'b0);

      // Collision: data first, then fetch after the turnaround cycle.
      if_req = 1'b1; if_addr = 16'h0020; mem_rd = 1'b1; mem_addr = 16'h0200;
      tick();
      check("t2_data_first", {ram_req, ram_we, ram_addr}, {1'b1, 1'b0, 16'h0200});
      tick();
      check("t2_turnaround", {mem_done, ram_req, if_done}, 3'b100);
      check("t2_rdata", mem_rdata, 16'h00FF);
      mem_rd = 1'b0;
      tick();
      check("t2_fetch", {ram_req, ram_we, ram_addr}, {1'b1, 1'b0, 16'h0020});
      tick();
      check("t2_if_done", {if_done, if_instr}, {1'b1, 16'h1234});
      if_req = 1'b0;
      tick();

      // Starvation guard.
      w0 = ram_writes; stores = 0; stores_at = -1; cnt_at = -1; fetch_seen = 1'b0;
      if_req = 1'b1; if_addr = 16'h0030;
      mem_wr = 1'b1; mem_addr = 16'h0100; mem_wdata = 16'h5A5A;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (mem_done) stores = stores + 1;
         if (ram_req && !ram_we && !fetch_seen) begin
            fetch_seen = 1'b1;
            stores_at  = stores;
            cnt_at     = int'(u_dut.w_starve_cnt);
            mem_wr     = 1'b0;
         end
         if (if_done) break;
      end
      check("t3_fetch_granted", fetch_seen, 1'b1);
      check("t3_stores_before", stores_at, 4);
      check("t3_starve_cleared", cnt_at, 0);
      check("t3_ram_writes", ram_writes - w0, 4);
      check("t3_instr", {if_done, if_instr}, {1'b1, 16'hC0DE});
      if_req = 1'b0; mem_wr = 1'b0;
      tick();

      // Slow RAM store.
      ack_delay = 3;
      mem_wr = 1'b1; mem_addr = 16'h0044; mem_wdata = 16'hBEEF;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("t4_hold", {ram_req, ram_we, ram_addr, ram_wdata, mem_stall, mem_done},
               {1'b1, 1'b1, 16'h0044, 16'hBEEF, 1'b1, 1'b0});
         tick();
      end
      check("t4_done", {mem_done, mem_stall, ram_req}, 3'b100);
      check("t4_written", tb_mem[16'h0044], 16'hBEEF);
      mem_wr = 1'b0; ack_delay = 0;
      tick();

      // Reset during a fetch, then a stray ack.
      ack_delay = 100;
      if_req = 1'b1; if_addr = 16'h0010;
      tick();
      check("t5_req", ram_req, 1'b1);
      reset = 1'b1; if_req = 1'b0;
      #1;
      check("t5_async_drop", {ram_req, u_dut.r_state}, 3'b000);
      tick();
      reset = 1'b0; ack_delay = 0; force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      check("t5_ack_ignored", {if_done, ram_req, u_dut.r_state}, 4'b0000);
      tick();
      check("t5_no_done", {if_done, u_dut.r_state}, 3'b000);

`ifdef ARB_FETCH_BUF_EN
      do_fetch("t6_first", 16'h0010, 16'h3A41, 1'b1);
      base = req_cycles;
      do_fetch("t6_hit", 16'h0010, 16'h3A41, 1'b0);
      check("t6_no_ram", req_cycles - base, 0);
`else
      do_fetch("t6_first", 16'h0010, 16'h3A41, 1'b1);
      base = req_cycles;
      do_fetch("t6_again", 16'h0010, 16'h3A41, 1'b1);
      check("t6_ram_used", req_cycles - base, 1);
`endif
      mem_wr = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'h7777;
      tick(); tick();
      check("t6_store_done", mem_done, 1'b1);
      mem_wr = 1'b0;
      tick();
      do_fetch("t6_refetch", 16'h0010, 16'h7777, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
